// File: rtl/bound_flasher_gen_pkg.sv
// Shared state encoding, bound-target selection and parameter legality helpers
// for the bound flasher.
package bound_flasher_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP_FULL = 3'd1;
  localparam logic [2:0] ST_DN_A    = 3'd2;
  localparam logic [2:0] ST_UP_B    = 3'd3;
  localparam logic [2:0] ST_DN_ZERO = 3'd4;
  localparam logic [2:0] ST_UP_C    = 3'd5;
  localparam logic [2:0] ST_DN_END  = 3'd6;

  function automatic int target_of(input logic [2:0] st, input int width, input int lo_a,
                                   input int hi_b, input int hi_c);
    case (st)
      ST_UP_FULL: return width;
      ST_DN_A:    return lo_a;
      ST_UP_B:    return hi_b;
      ST_UP_C:    return hi_c;
      default:    return 0;
    endcase
  endfunction

  function automatic logic is_up(input logic [2:0] st);
    return (st == ST_UP_FULL) || (st == ST_UP_B) || (st == ST_UP_C);
  endfunction

  function automatic logic params_legal(input int width, input int lo_a, input int hi_b,
                                        input int hi_c, input int step_div);
    return (lo_a >= 1) && (lo_a <= width - 1) &&
           (hi_b >= lo_a + 1) && (hi_b <= width) &&
           (hi_c >= 1) && (hi_c <= width) &&
           (step_div >= 1);
  endfunction

endpackage

// File: rtl/bound_flasher_gen_tick.sv
// Step-rate prescaler: one tick every STEP_DIV enabled cycles; the count is
// frozen while hold is high and cleared whenever the sequencer is idle.
module bf_tick_gen #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bound_flasher_gen.sv
// Bound flasher: walks a thermometer LED bar through six up/down phases with
// programmable bounds, a step prescaler and capped flick kickbacks.
//
// state      | meaning
// IDLE       | waiting for flick, bar dark
// UP_FULL    | climb to WIDTH
// DN_A       | fall to LO_A, may kick back to UP_FULL
// UP_B       | climb to HI_B
// DN_ZERO    | fall to 0, may kick back to UP_B
// UP_C       | climb to HI_C
// DN_END     | fall to 0, then run_done
module bound_flasher_gen
  import bound_flasher_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LO_A        = 6,
  parameter int HI_B        = 11,
  parameter int HI_C        = 6,
  parameter int STEP_DIV    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_KB      = 0,
  parameter int REPEAT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flick,
  input  logic             hold,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             dir_up,
  output logic             kick_pulse,
  output logic             run_done
);

  localparam int NW = $clog2(WIDTH + 1);
  localparam int KW = (MAX_KB > 0) ? $clog2(MAX_KB + 1) : 1;

  if (!params_legal(WIDTH, LO_A, HI_B, HI_C, STEP_DIV)) begin : g_illegal
    $error("bound_flasher_gen: illegal LO_A/HI_B/HI_C/STEP_DIV combination");
  end

  logic flick_s, hold_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign flick_s = flick;
    assign hold_s  = hold;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] fsync, hsync;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fsync <= '0;
        hsync <= '0;
      end else begin
        fsync <= SYNC_STAGES'({fsync, flick});
        hsync <= SYNC_STAGES'({hsync, hold});
      end
    end
    assign flick_s = fsync[SYNC_STAGES-1];
    assign hold_s  = hsync[SYNC_STAGES-1];
  end

  logic [2:0]       state, state_nxt;
  logic [NW-1:0]    n, n_nxt, tgt;
  logic [KW-1:0]    kb_cnt, kb_nxt;
  logic             pend, pend_nxt;
  logic             kick_nxt, done_nxt, kick_ok, tick;
  logic [WIDTH-1:0] led_nxt;

  assign busy   = (state != ST_IDLE);
  assign dir_up = is_up(state);

  bf_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .hold (hold_s),
    .tick (tick)
  );

  assign tgt     = NW'(target_of(state, WIDTH, LO_A, HI_B, HI_C));
  assign kick_ok = (flick_s || pend) && ((MAX_KB == 0) || (int'(kb_cnt) < MAX_KB));

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    kb_nxt    = kb_cnt;
    pend_nxt  = pend;
    kick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if ((state == ST_DN_A || state == ST_DN_ZERO) && flick_s) pend_nxt = 1'b1;
    if (state == ST_IDLE) begin
      if (flick_s) begin
        state_nxt = ST_UP_FULL;
        kb_nxt    = '0;
      end
    end else if (tick) begin
      // Bound compare comes first so n can never step past a target.
      if (n != tgt) begin
        n_nxt = dir_up ? n + NW'(1) : n - NW'(1);
      end else begin
        pend_nxt = 1'b0;
        case (state)
          ST_UP_FULL: state_nxt = ST_DN_A;
          ST_DN_A: begin
            if (kick_ok) begin
              state_nxt = ST_UP_FULL;
              kick_nxt  = 1'b1;
              if (MAX_KB != 0) kb_nxt = kb_cnt + KW'(1);
            end else begin
              state_nxt = ST_UP_B;
            end
          end
          ST_UP_B: state_nxt = ST_DN_ZERO;
          ST_DN_ZERO: begin
            if (kick_ok) begin
              state_nxt = ST_UP_B;
              kick_nxt  = 1'b1;
              if (MAX_KB != 0) kb_nxt = kb_cnt + KW'(1);
            end else begin
              state_nxt = ST_UP_C;
            end
          end
          ST_UP_C: state_nxt = ST_DN_END;
          ST_DN_END: begin
            done_nxt = 1'b1;
            if (REPEAT != 0) begin
              state_nxt = ST_UP_FULL;
              kb_nxt    = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < WIDTH; i++) led_nxt[i] = (i < int'(n_nxt));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      n          <= '0;
      led        <= '0;
      kb_cnt     <= '0;
      pend       <= 1'b0;
      kick_pulse <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      n          <= n_nxt;
      led        <= led_nxt;
      kb_cnt     <= kb_nxt;
      pend       <= pend_nxt;
      kick_pulse <= kick_nxt;
      run_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bound_flasher_gen.sv
// Bench for bound_flasher_gen: default, MAX_KB=2 and STEP_DIV=4 instances
// checked with a start-up vector table, a led scoreboard and corner sequences.
module tb_bound_flasher_gen;

  logic clk, rst;
  logic flick, hold, f_kb, f_div, h_div;
  logic [15:0] led, led_kb, led_div;
  logic busy, dir_up, kick, done;
  logic busy_kb, dir_kb, kick_kb, done_kb;
  logic busy_div, dir_div, kick_div, done_div;

  int checks = 0;
  int failures = 0;

  bound_flasher_gen dut (
    .clk(clk), .rst(rst), .flick(flick), .hold(hold), .led(led),
    .busy(busy), .dir_up(dir_up), .kick_pulse(kick), .run_done(done));

  bound_flasher_gen #(.MAX_KB(2)) dut_kb (
    .clk(clk), .rst(rst), .flick(f_kb), .hold(1'b0), .led(led_kb),
    .busy(busy_kb), .dir_up(dir_kb), .kick_pulse(kick_kb), .run_done(done_kb));

  bound_flasher_gen #(.STEP_DIV(4)) dut_div (
    .clk(clk), .rst(rst), .flick(f_div), .hold(h_div), .led(led_div),
    .busy(busy_div), .dir_up(dir_div), .kick_pulse(kick_div), .run_done(done_div));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flick;
    logic        hold;
    logic [15:0] led;
    logic        busy;
    logic        dir_up;
  } vec_t;

  typedef struct {
    logic [15:0] led;
    logic        done;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] thermo(input int lvl);
    logic [31:0] one;
    one = 32'd1;
    return 16'((one << lvl) - 32'd1);
  endfunction

  initial begin
    int tg[6];
    int lvl, cnt, kicks;
    logic got;
    exp_t e;

    vecs[0] = '{flick: 1'b0, hold: 1'b1, led: 16'h0000, busy: 1'b0, dir_up: 1'b0};
    vecs[1] = '{flick: 1'b1, hold: 1'b1, led: 16'h0000, busy: 1'b0, dir_up: 1'b0};
    vecs[2] = '{flick: 1'b0, hold: 1'b0, led: 16'h0000, busy: 1'b0, dir_up: 1'b0};
    vecs[3] = '{flick: 1'b0, hold: 1'b0, led: 16'h0000, busy: 1'b1, dir_up: 1'b1};
    tg = '{16, 6, 11, 0, 6, 0};

    rst = 1'b0; flick = 1'b0; hold = 1'b0; f_kb = 1'b0; f_div = 1'b0; h_div = 1'b0;
    repeat (3) step();
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_dir", {31'h0, dir_up}, 32'h0);
    chk("reset_kick", {31'h0, kick}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_led_kb", {16'h0, led_kb}, 32'h0);
    chk("reset_dir_kb", {31'h0, dir_kb}, 32'h0);
    chk("reset_done_div", {31'h0, done_div}, 32'h0);
    rst = 1'b1;
    repeat (3) step();

    // Start-up latency and hold ignored in IDLE.
    for (int i = 0; i < 4; i++) begin
      flick = vecs[i].flick;
      hold  = vecs[i].hold;
      step();
      chk($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].led});
      chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
      chk($sformatf("vec%0d_dir", i), {31'h0, dir_up}, {31'h0, vecs[i].dir_up});
    end

    // Full default run through the scoreboard.
    lvl = 0;
    for (int p = 0; p < 6; p++) begin
      while (lvl != tg[p]) begin
        lvl += (tg[p] > lvl) ? 1 : -1;
        sb.push_back('{led: thermo(lvl), done: 1'b0});
      end
      sb.push_back('{led: thermo(lvl), done: (p == 5)});
    end
    cnt = 0;
    while (sb.size() > 0) begin
      step();
      cnt++;
      e = sb.pop_front();
      chk($sformatf("run1_led_t%0d", cnt), {16'h0, led}, {16'h0, e.led});
      chk($sformatf("run1_done_t%0d", cnt), {31'h0, done}, {31'h0, e.done});
    end
    chk("run1_ticks", cnt, 60);
    chk("run1_busy_end", {31'h0, busy}, 32'h0);
    repeat (4) step();

    // Flick held through DN_A end: kickback to UP_FULL.
    flick = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) step();
    chk("run2_start", {31'h0, busy}, 32'h1);
    for (int j = 1; j <= 28; j++) begin
      step();
      if (j == 27) begin
        chk("run2_led_lo", {16'h0, led}, 32'h003F);
        chk("run2_nokick", {31'h0, kick}, 32'h0);
      end
    end
    chk("run2_kick", {31'h0, kick}, 32'h1);
    chk("run2_kick_led", {16'h0, led}, 32'h003F);
    chk("run2_kick_dir", {31'h0, dir_up}, 32'h1);
    flick = 1'b0;
    step();
    chk("run2_climb", {16'h0, led}, 32'h007F);
    chk("run2_kick_clr", {31'h0, kick}, 32'h0);
    cnt = 1; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done) got = 1'b1;
      else begin step(); cnt++; end
    end
    chk("run2_done_seen", {31'h0, got}, 32'h1);
    chk("run2_done_ticks", cnt, 54);
    repeat (4) step();

    // Flick pulse mid DN_ZERO: pending kickback to UP_B at n=0.
    flick = 1'b1;
    step();
    flick = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) step();
    chk("run3_start", {31'h0, busy}, 32'h1);
    for (int t = 1; t <= 84; t++) begin
      step();
      if (t == 28) chk("run3_no_dna_kick", {31'h0, kick}, 32'h0);
      if (t == 38) flick = 1'b1;
      if (t == 39) flick = 1'b0;
      if (t == 46) begin
        chk("run3_kick", {31'h0, kick}, 32'h1);
        chk("run3_kick_led", {16'h0, led}, 32'h0);
        chk("run3_kick_dir", {31'h0, dir_up}, 32'h1);
      end
      if (t == 57) chk("run3_upb_top", {16'h0, led}, 32'h07FF);
      if (t == 83) chk("run3_not_done", {31'h0, done}, 32'h0);
    end
    chk("run3_done", {31'h0, done}, 32'h1);
    repeat (4) step();

    // MAX_KB=2 with flick tied high.
    f_kb = 1'b1;
    for (int i = 0; i < 20 && !busy_kb; i++) step();
    chk("kb_start", {31'h0, busy_kb}, 32'h1);
    cnt = 0; kicks = 0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      cnt++;
      if (kick_kb) kicks++;
      if (done_kb) got = 1'b1;
    end
    f_kb = 1'b0;
    chk("kb_done_seen", {31'h0, got}, 32'h1);
    chk("kb_kicks", kicks, 2);
    chk("kb_ticks", cnt, 104);

    // STEP_DIV=4, hold for 10 cycles at n=8.
    f_div = 1'b1;
    step();
    f_div = 1'b0;
    for (int i = 0; i < 20 && !busy_div; i++) step();
    chk("div_start", {31'h0, busy_div}, 32'h1);
    for (int j = 1; j <= 50; j++) begin
      step();
      if (j == 4) chk("div_first_tick", {16'h0, led_div}, 32'h0001);
      if (j >= 32 && j <= 45) chk($sformatf("div_frozen_c%0d", j), {16'h0, led_div}, 32'h00FF);
      if (j == 33) h_div = 1'b1;
      if (j == 43) h_div = 1'b0;
      if (j == 46) chk("div_resume", {16'h0, led_div}, 32'h01FF);
      if (j == 49) chk("div_phase_kept", {16'h0, led_div}, 32'h01FF);
      if (j == 50) begin
        chk("div_next", {16'h0, led_div}, 32'h03FF);
        chk("div_dir", {31'h0, dir_div}, 32'h1);
        chk("div_nokick", {31'h0, kick_div}, 32'h0);
      end
    end

    // Asynchronous reset mid UP_B.
    flick = 1'b1;
    step();
    flick = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) step();
    chk("run6_start", {31'h0, busy}, 32'h1);
    repeat (31) step();
    chk("run6_upb_n9", {16'h0, led}, 32'h01FF);
    #2 rst = 1'b0;
    #1;
    chk("run6_rst_led", {16'h0, led}, 32'h0);
    chk("run6_rst_busy", {31'h0, busy}, 32'h0);
    chk("run6_rst_dir", {31'h0, dir_up}, 32'h0);
    #3 rst = 1'b1;
    repeat (6) step();
    chk("run6_idle_busy", {31'h0, busy}, 32'h0);
    chk("run6_idle_led", {16'h0, led}, 32'h0);
    flick = 1'b1;
    step();
    flick = 1'b0;
    for (int i = 0; i < 20 && !busy; i++) step();
    chk("run6_restart", {31'h0, busy}, 32'h1);
    step();
    chk("run6_first_step", {16'h0, led}, 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
